// File: rtl/master_req_shaper.sv
// Turns per-master job starts into req/done levels for the 3-master access controller.
// Tracks ownership through accmodule, resumes preempted jobs, counts preemptions and flags starvation.
module master_req_shaper #(
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         start,
  input  logic [3*LEN_W-1:0] len,
  input  logic [1:0]         accmodule,
  output logic [2:0]         req,
  output logic [2:0]         done,
  output logic [2:0]         busy,
  output logic [2:0]         starve,
  output logic [CNT_W-1:0]   preempt_cnt,
  output logic [5:0]         state_dbg
);

  // Handshake: req[i] rises the edge a job is accepted and holds (through preemptions) until the
  // edge that consumes its last owned beat; on that same edge done[i] pulses high for one cycle.
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t            state_q [3];
  state_t            state_d [3];
  logic [LEN_W-1:0]  rem_q   [3];
  logic [LEN_W-1:0]  rem_d   [3];
  logic [WAIT_W-1:0] wait_q  [3];
  logic [WAIT_W-1:0] wait_d  [3];
  logic [2:0]        req_d;
  logic [2:0]        done_d;
  logic [2:0]        starve_d;
  logic [CNT_W-1:0]  preempt_d;
  logic [1:0]        npre;
  logic [CNT_W+1:0]  pre_sum;
  logic [2:0]        own;

  assign own = {accmodule == 2'd3, accmodule == 2'd2, accmodule == 2'd1};

  always_comb begin
    req_d     = req;
    done_d    = 3'b000;
    starve_d  = starve;
    npre      = 2'd0;
    preempt_d = preempt_cnt;
    pre_sum   = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      wait_d[i]  = wait_q[i];
      case (state_q[i])
        S_IDLE: begin
          req_d[i] = 1'b0;
          if (start[i]) begin
            state_d[i] = S_WAIT;
            rem_d[i]   = (len[i*LEN_W +: LEN_W] == '0) ? LEN_W'(1) : len[i*LEN_W +: LEN_W];
            wait_d[i]  = '0;
            req_d[i]   = 1'b1;
          end
        end
        S_WAIT, S_ACTIVE: begin
          if (own[i]) begin
            wait_d[i] = '0;
            if (rem_q[i] == LEN_W'(1)) begin
              state_d[i] = S_IDLE;
              rem_d[i]   = '0;
              done_d[i]  = 1'b1;
              req_d[i]   = 1'b0;
            end else begin
              state_d[i] = S_ACTIVE;
              rem_d[i]   = rem_q[i] - 1'b1;
            end
          end else if (state_q[i] == S_ACTIVE) begin
            state_d[i] = S_WAIT;
            npre       = npre + 2'd1;
          end else begin
            if (wait_q[i] != WAIT_W'(MAX_WAIT)) wait_d[i] = wait_q[i] + 1'b1;
            if (wait_d[i] == WAIT_W'(MAX_WAIT)) starve_d[i] = 1'b1;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          req_d[i]   = 1'b0;
        end
      endcase
    end
    // Wide enough that adding up to three preemptions never wraps before the clamp.
    pre_sum = {2'b00, preempt_cnt} + {{CNT_W{1'b0}}, npre};
    if (pre_sum > {2'b00, {CNT_W{1'b1}}}) preempt_d = '1;
    else                                  preempt_d = pre_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= S_IDLE;
        rem_q[i]   <= '0;
        wait_q[i]  <= '0;
      end
      req         <= 3'b000;
      done        <= 3'b000;
      starve      <= 3'b000;
      preempt_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
        wait_q[i]  <= wait_d[i];
      end
      req         <= req_d;
      done        <= done_d;
      starve      <= starve_d;
      preempt_cnt <= preempt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) busy[i] = (state_q[i] != S_IDLE);
    state_dbg = {state_q[2], state_q[1], state_q[0]};
  end

endmodule

// File: tb/tb_master_req_shaper.sv
// Bench for master_req_shaper: directed scenarios plus random traffic, all cycles scored
// against a job-level model (beats left, owned-last-cycle, consecutive unowned cycles).
module tb_master_req_shaper;

  localparam int LEN_W    = 4;
  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 8;
  localparam int W        = 12 + CNT_W;

  logic               clk = 1'b0;
  logic               reset;
  logic [2:0]         start;
  logic [3*LEN_W-1:0] len;
  logic [1:0]         accmodule;
  logic [2:0]         req, done, busy, starve;
  logic [CNT_W-1:0]   preempt_cnt;
  logic [5:0]         state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  master_req_shaper #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .accmodule(accmodule),
    .req(req), .done(done), .busy(busy), .starve(starve),
    .preempt_cnt(preempt_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit  m_busy [3];
  int  m_left [3];
  bit  m_held [3];
  int  m_wait [3];
  logic [2:0] m_done, m_starve;
  int  m_pre;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i] = 0; m_left[i] = 0; m_held[i] = 0; m_wait[i] = 0;
      end
      m_done = '0; m_starve = '0; m_pre = 0;
    end else begin
      m_done = '0;
      for (int i = 0; i < 3; i++) begin
        if (!m_busy[i]) begin
          if (start[i]) begin
            m_busy[i] = 1;
            m_left[i] = (len[i*LEN_W +: LEN_W] == 0) ? 1 : int'(len[i*LEN_W +: LEN_W]);
            m_held[i] = 0;
            m_wait[i] = 0;
          end
        end else if (int'(accmodule) == i + 1) begin
          m_left[i]--;
          m_held[i] = 1;
          m_wait[i] = 0;
          if (m_left[i] == 0) begin
            m_busy[i] = 0; m_done[i] = 1'b1; m_held[i] = 0;
          end
        end else if (m_held[i]) begin
          m_held[i] = 0;
          m_pre++;
        end else begin
          m_wait[i]++;
          if (m_wait[i] >= MAX_WAIT) m_starve[i] = 1'b1;
        end
      end
      if (m_pre > (1 << CNT_W) - 1) m_pre = (1 << CNT_W) - 1;
    end
    exp_q.push_back({m_busy[2], m_busy[1], m_busy[0], m_done,
                     m_busy[2], m_busy[1], m_busy[0], m_starve, CNT_W'(m_pre)});
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("sb_req",     32'(req),         32'(e[W-1 -: 3]));
      check("sb_done",    32'(done),        32'(e[W-4 -: 3]));
      check("sb_busy",    32'(busy),        32'(e[W-7 -: 3]));
      check("sb_starve",  32'(starve),      32'(e[W-10 -: 3]));
      check("sb_preempt", 32'(preempt_cnt), 32'(e[CNT_W-1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] s, input logic [3:0] l2, input logic [3:0] l1,
                       input logic [3:0] l0, input logic [1:0] a);
    start = s; len = {l2, l1, l0}; accmodule = a;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // T1: reset with all starts asserted
    reset = 1'b1;
    drive(3'b111, 4'd5, 4'd5, 4'd5, 2'd0);
    tick(1);
    reset = 1'b0;
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd0);
    check("t1_req", 32'(req), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_preempt", 32'(preempt_cnt), 32'd0);
    tick(1);
    check("t1_req_after_release", 32'(req), 32'd0);

    // T2: single M2 job of 3 beats
    drive(3'b010, 4'd0, 4'd3, 4'd0, 2'd0);
    tick(1);
    check("t2_req_rise", 32'(req), 32'b010);
    for (int k = 0; k < 3; k++) begin
      drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd2);
      tick(1);
      if (k < 2) check("t2_req_held", 32'(req[1]), 32'd1);
    end
    check("t2_done", 32'(done), 32'b010);
    check("t2_req_drop", 32'(req), 32'b000);
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd0);
    tick(1);
    check("t2_done_one_cycle", 32'(done), 32'b000);

    // T3: preemption of a 4-beat M2 job
    drive(3'b010, 4'd0, 4'd4, 4'd0, 2'd0);
    tick(1);
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd2);
    tick(2);
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd1);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("t3_req_held", 32'(req[1]), 32'd1);
    end
    check("t3_preempt", 32'(preempt_cnt), 32'd1);
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd2);
    tick(1);
    check("t3_not_done_yet", 32'(done), 32'd0);
    tick(1);
    check("t3_done", 32'(done), 32'b010);

    // T4: len=0 treated as one beat, restart in the done cycle
    drive(3'b001, 4'd0, 4'd0, 4'd0, 2'd0);
    tick(1);
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd1);
    tick(1);
    check("t4_done_len0", 32'(done), 32'b001);
    check("t4_req_drop", 32'(req[0]), 32'd0);
    drive(3'b001, 4'd0, 4'd0, 4'd2, 2'd0);
    tick(1);
    check("t4_req_back", 32'(req[0]), 32'd1);
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd1);
    tick(2);
    check("t4_second_done", 32'(done), 32'b001);

    // T5: starvation of M3
    drive(3'b100, 4'd2, 4'd0, 4'd0, 2'd0);
    tick(1);
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd0);
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (k == 14) check("t5_not_yet_starved", 32'(starve), 32'b000);
    end
    check("t5_starve", 32'(starve), 32'b100);
    check("t5_busy", 32'(busy[2]), 32'd1);
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd3);
    tick(3);
    check("t5_starve_sticky", 32'(starve), 32'b100);

    // T6a: start while busy must not reload the job
    drive(3'b001, 4'd0, 4'd0, 4'd3, 2'd0);
    tick(1);
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd1);
    tick(1);
    drive(3'b001, 4'd0, 4'd0, 4'd15, 2'd1);
    tick(1);
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd1);
    tick(1);
    check("t6_ignored_start_done", 32'(done), 32'b001);

    // random traffic with occasional mid-job resets
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      len   = 12'($urandom());
      accmodule = 2'($urandom_range(0, 3));
      tick(1);
    end

    // T6b: force far more than 255 preemptions
    reset = 1'b1;
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd0);
    tick(1);
    reset = 1'b0;
    for (int k = 0; k < 400; k++) begin
      drive(3'b111, 4'd15, 4'd15, 4'd15, 2'(1 + (k % 3)));
      tick(1);
    end
    check("t6_preempt_sat", 32'(preempt_cnt), 32'd255);
    drive(3'b000, 4'd0, 4'd0, 4'd0, 2'd0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    check("timeout", 32'd1, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
